apb_reg_slave: RTL and testbench
================================

Name: apb_reg_slave

Overview:
- APB completer (responder) for the `apb_if` bus: it answers transfers started by an APB initiator.
- Exposes a small register file: CTRL (enable bit), COUNT (read-only up-counter gated by the enable bit), and NUM_SCRATCH general read/write scratch words.
- Sits behind the bus fabric as the peripheral-side endpoint, with a parameterised number of wait states.

Parameters:
- ADDR_W, 8, number of `paddr` bits decoded; upper `paddr` bits are ignored.
- NUM_SCRATCH, 2, number of 32-bit scratch registers (1..16).
- WAIT_STATES, 0, cycles of `pready`=0 inserted in each access phase (0..15).
- COUNT_W, 8, COUNT register width (1..32); read back zero-extended to 32 bits.

Ports:
- pclk  input  1  bus clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- psel  input  1  completer select.
- penable  input  1  access-phase strobe.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  32  byte address.
- pwdata  input  32  write data.
- prdata  output  32  read data; valid only when pready=1 and the transfer is a read.
- pready  output  1  transfer completes this cycle.
- pslverr  output  1  error response; valid only when pready=1.
- count_en  output  1  mirror of CTRL[0].

Behaviour:
- Clock and reset:
  - Single clock `pclk`.
  - `rst` is synchronous and active-high: it is sampled on the `pclk` rising edge.
  - Reset values: FSM=IDLE, CTRL=0, COUNT=0, all scratch=0, `pready`=0, `pslverr`=0, `prdata`=0, `count_en`=0.
- Address map:
  - Decode uses `paddr[ADDR_W-1:0]`; `idx` = `paddr[ADDR_W-1:2]`.
  - 0x00 CTRL: RW; only bit0 is stored; other bits read 0.
  - 0x04 COUNT: RO.
  - 0x08 + 4*k SCRATCH[k]: RW, 32 bits, for k < NUM_SCRATCH.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS: edge with `psel`=1 and `penable`=0 (setup phase). That edge latches `pwrite`, `paddr`, `pwdata` and loads `wcnt`=WAIT_STATES.
  - IDLE with `penable`=1 and no prior setup: protocol violation; ignored, stay IDLE, `pready`=0.
  - ACCESS with `psel`=1 and `penable`=1 and `wcnt`!=0: `wcnt` decrements; `pready`=0.
  - ACCESS with `wcnt`==0: `pready`=1 (combinational from state and `wcnt`). On the next edge, return to IDLE.
  - ACCESS with `psel`=0: abort; return to IDLE with no side effects.
  - Back-to-back transfers: the initiator drives a new setup on the cycle after completion. IDLE accepts it normally, so a 0-wait transfer takes 2 cycles.
- Latency: WAIT_STATES=0 gives `pready` in the first access cycle (2-cycle transfer). Each extra wait state adds one cycle.
- Error: `pslverr` = `pready` AND any of:
  - misaligned (`paddr[1:0]`!=0);
  - `idx` >= 2+NUM_SCRATCH;
  - write to COUNT.
- Write commit:
  - Occurs on the edge where `pready`=1, the transfer is a write, and `pslverr`=0.
  - Uses the latched `pwdata`.
  - An errored write changes nothing.
- Read data:
  - `prdata` = selected register when `pready`=1 and the transfer is a read and `pslverr`=0; otherwise 0.
  - COUNT reads return the value at the completing cycle, before that edge's increment.
- COUNT behaviour:
  - Each edge: if CTRL[0]=1, COUNT <= COUNT+1, wrapping (2^COUNT_W-1) -> 0. Otherwise COUNT <= 0.
  - A CTRL write that clears bit0 zeroes COUNT from the following edge.
  - A CTRL write that sets bit0 starts incrementing from the following edge.
- Simultaneous events: `rst` wins over everything, including a completing write.
- Reset mid-transfer: the transfer is dropped; `pready` stays 0 until the next full setup/access sequence.

Decomposition:
- Package `apb_pkg`:
  - `typedef enum {IDLE, ACCESS}` for the FSM state;
  - localparams `CTRL_OFS`=0x00, `COUNT_OFS`=0x04, `SCRATCH_OFS`=0x08;
  - `APB_DW`=32.
- One sub-module, `apb_en_counter`: parameter COUNT_W, ports `pclk`, `rst`, `en`, `count`; implements the gated wrap/clear counter.
- FSM, address decode and register file stay in `apb_reg_slave`.

Test Plan:
- Reset then read 0x00, 0x04, 0x08, WAIT_STATES=0 -> each completes in 2 cycles, `prdata`=0, `pslverr`=0.
- Write 0x08=0xDEADBEEF, read 0x08 -> 0xDEADBEEF. With WAIT_STATES=3, `pready` stays low 3 access cycles and rises on the 4th.
- Write 0x00=1, then 5 idle cycles, read 0x04 -> nonzero and incrementing. Let it run 256+ cycles -> wraps through 0xFF -> 0x00. Write 0x00=0 -> COUNT reads 0.
- Write to 0x04, write to 0x10 (out of range with NUM_SCRATCH=2), read 0x0A (misaligned) -> each gets `pslverr`=1 with `pready`, `prdata`=0, no register changed.
- Assert `rst` during ACCESS with WAIT_STATES=2 on a write of 0x55 to 0x0C -> SCRATCH[1] stays 0, `pready` never asserted. Abort by dropping `psel` mid-wait -> FSM returns to IDLE with no write.
- Back-to-back write 0x08 then read 0x08 with no idle cycle, plus a stray `penable` pulse while IDLE -> read returns the written value, and the stray pulse yields no `pready`.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and register map for the APB register completer.
package apb_pkg;

  localparam int APB_DW = 32;

  localparam logic [APB_DW-1:0] CTRL_OFS    = 32'h00;
  localparam logic [APB_DW-1:0] COUNT_OFS   = 32'h04;
  localparam logic [APB_DW-1:0] SCRATCH_OFS = 32'h08;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_t;

endpackage

// File: rtl/apb_en_counter.sv
// Free-running up-counter that wraps at 2^COUNT_W and is held at zero
// whenever the enable input is low.
module apb_en_counter #(
  parameter int COUNT_W = 8
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               en,
  output logic [COUNT_W-1:0] count
);

  // Increment while enabled, clear to zero while disabled.
  always_ff @(posedge pclk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + COUNT_W'(1);
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer exposing CTRL, a gated COUNT register and NUM_SCRATCH
// scratch words, with a fixed number of wait states per access phase.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int NUM_SCRATCH = 2,
  parameter int WAIT_STATES = 0,
  parameter int COUNT_W     = 8
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_DW-1:0] paddr,
  input  logic [APB_DW-1:0] pwdata,
  output logic [APB_DW-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              count_en
);

  apb_state_t         state;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [APB_DW-1:0]  wdata_q;
  logic [3:0]         wcnt;

  logic               ctrl;
  logic [COUNT_W-1:0] count;
  logic [APB_DW-1:0]  scratch [NUM_SCRATCH];

  logic [APB_DW-1:0]  ofs;
  logic [APB_DW-1:0]  rdata_sel;
  logic               misaligned;
  logic               out_of_range;
  logic               ro_write;
  logic               commit;

  // Upper address bits beyond ADDR_W are intentionally not decoded.
  logic               unused_paddr;
  assign unused_paddr = ^paddr;

  // Word-aligned byte offset of the latched address.
  assign ofs          = 32'(addr_q) & ~32'h3;
  assign misaligned   = (addr_q[1:0] != 2'b00);
  assign out_of_range = (ofs >= SCRATCH_OFS + 32'(4 * NUM_SCRATCH));
  assign ro_write     = wr_q && (ofs == COUNT_OFS);

  // Completion is purely a function of state and the wait counter.
  assign pready   = (state == ACCESS) && (wcnt == 4'd0);
  assign pslverr  = pready && (misaligned || out_of_range || ro_write);
  assign commit   = pready && wr_q && !pslverr;
  assign count_en = ctrl;

  // Transfer FSM: latch the setup phase, count down waits, then complete.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wcnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // An access-phase strobe without a prior setup is ignored.
          if (psel && !penable) begin
            state   <= ACCESS;
            wr_q    <= pwrite;
            addr_q  <= paddr[ADDR_W-1:0];
            wdata_q <= pwdata;
            wcnt    <= 4'(WAIT_STATES);
          end
        end
        ACCESS: begin
          if (wcnt == 4'd0) begin
            state <= IDLE;
          end else if (!psel) begin
            // Initiator abandoned the transfer: leave without side effects.
            state <= IDLE;
          end else if (penable) begin
            wcnt <= wcnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register file writes commit only on an error-free completing write.
  always_ff @(posedge pclk) begin
    if (rst) begin
      ctrl <= 1'b0;
      for (int k = 0; k < NUM_SCRATCH; k++) begin
        scratch[k] <= '0;
      end
    end else if (commit) begin
      if (ofs == CTRL_OFS) begin
        ctrl <= wdata_q[0];
      end
      for (int k = 0; k < NUM_SCRATCH; k++) begin
        if (ofs == SCRATCH_OFS + 32'(4 * k)) begin
          scratch[k] <= wdata_q;
        end
      end
    end
  end

  // Read mux over the register map; unmapped offsets read zero.
  always_comb begin
    rdata_sel = '0;
    if (ofs == CTRL_OFS) begin
      rdata_sel[0] = ctrl;
    end else if (ofs == COUNT_OFS) begin
      rdata_sel[COUNT_W-1:0] = count;
    end
    for (int k = 0; k < NUM_SCRATCH; k++) begin
      if (ofs == SCRATCH_OFS + 32'(4 * k)) begin
        rdata_sel = scratch[k];
      end
    end
  end

  assign prdata = (pready && !wr_q && !pslverr) ? rdata_sel : '0;

  apb_en_counter #(
    .COUNT_W (COUNT_W)
  ) u_counter (
    .pclk  (pclk),
    .rst   (rst),
    .en    (ctrl),
    .count (count)
  );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: three instances with 0, 3 and 2 wait
// states share the bus wires and are selected by their own psel.
module tb_apb_reg_slave;

  logic              pclk = 1'b0;
  logic              rst;
  logic [2:0]        psel_v;
  logic              penable;
  logic              pwrite;
  logic [31:0]       paddr;
  logic [31:0]       pwdata;
  logic [2:0][31:0]  prdata_v;
  logic [2:0]        pready_v;
  logic [2:0]        pslverr_v;
  logic [2:0]        count_en_v;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_reg_slave #(.ADDR_W(8), .NUM_SCRATCH(2), .WAIT_STATES(0), .COUNT_W(8)) u_ws0 (
    .pclk(pclk), .rst(rst), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
    .pslverr(pslverr_v[0]), .count_en(count_en_v[0]));

  apb_reg_slave #(.ADDR_W(8), .NUM_SCRATCH(2), .WAIT_STATES(3), .COUNT_W(8)) u_ws3 (
    .pclk(pclk), .rst(rst), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
    .pslverr(pslverr_v[1]), .count_en(count_en_v[1]));

  apb_reg_slave #(.ADDR_W(8), .NUM_SCRATCH(2), .WAIT_STATES(2), .COUNT_W(8)) u_ws2 (
    .pclk(pclk), .rst(rst), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
    .pslverr(pslverr_v[2]), .count_en(count_en_v[2]));

  typedef struct {
    int          d;
    bit          w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    bit          ee;
    int          cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic addv(input int d, input bit w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input bit ee);
    vec_t v;
    v.d = d; v.w = w; v.a = a; v.wd = wd; v.er = er; v.ee = ee;
    v.cyc = (d == 1) ? 4 : (d == 2) ? 3 : 1;
    vecs.push_back(v);
  endtask

  // Full setup+access transfer; returns with the bus idle one cycle after
  // completion so a following call forms a back-to-back transfer.
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int acc);
    psel_v    = '0;
    psel_v[d] = 1'b1;
    penable   = 1'b0;
    pwrite    = w;
    paddr     = a;
    pwdata    = wd;
    tick();
    penable = 1'b1;
    acc     = 1;
    while (pready_v[d] !== 1'b1 && acc < 40) begin
      tick();
      acc++;
    end
    if (pready_v[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout: dut %0d addr %h got no pready, required pready=1", d, a);
    end
    rd  = prdata_v[d];
    err = pslverr_v[d];
    tick();
    psel_v  = '0;
    penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          acc;

    rst = 1'b1; psel_v = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_pready%0d", d),   32'(pready_v[d]),   32'h0);
      chk($sformatf("rst_pslverr%0d", d),  32'(pslverr_v[d]),  32'h0);
      chk($sformatf("rst_prdata%0d", d),   prdata_v[d],        32'h0);
      chk($sformatf("rst_count_en%0d", d), 32'(count_en_v[d]), 32'h0);
    end

    addv(0, 0, 32'h00,  32'h0,        32'h0,        0);
    addv(0, 0, 32'h04,  32'h0,        32'h0,        0);
    addv(0, 0, 32'h08,  32'h0,        32'h0,        0);
    addv(0, 1, 32'h08,  32'hDEADBEEF, 32'h0,        0);
    addv(0, 0, 32'h08,  32'h0,        32'hDEADBEEF, 0);
    addv(0, 1, 32'h0C,  32'h12345678, 32'h0,        0);
    addv(0, 0, 32'h0C,  32'h0,        32'h12345678, 0);
    addv(0, 1, 32'h04,  32'h000000FF, 32'h0,        1);
    addv(0, 0, 32'h04,  32'h0,        32'h0,        0);
    addv(0, 1, 32'h10,  32'hAAAA5555, 32'h0,        1);
    addv(0, 0, 32'h0A,  32'h0,        32'h0,        1);
    addv(0, 0, 32'h10,  32'h0,        32'h0,        1);
    addv(0, 1, 32'h0A,  32'h00000001, 32'h0,        1);
    addv(0, 0, 32'h08,  32'h0,        32'hDEADBEEF, 0);
    addv(0, 0, 32'h108, 32'h0,        32'hDEADBEEF, 0);
    addv(0, 1, 32'h00,  32'hFFFFFFFE, 32'h0,        0);
    addv(0, 0, 32'h00,  32'h0,        32'h0,        0);
    addv(0, 0, 32'h0C,  32'h0,        32'h12345678, 0);
    addv(1, 1, 32'h08,  32'hCAFEF00D, 32'h0,        0);
    addv(1, 0, 32'h08,  32'h0,        32'hCAFEF00D, 0);
    addv(1, 0, 32'h0C,  32'h0,        32'h0,        0);
    addv(1, 1, 32'h14,  32'h00000001, 32'h0,        1);
    addv(1, 0, 32'h04,  32'h0,        32'h0,        0);

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, rd, err, acc);
      chk($sformatf("v%0d_prdata", i),  rd,       vecs[i].er);
      chk($sformatf("v%0d_pslverr", i), 32'(err), 32'(vecs[i].ee));
      chk($sformatf("v%0d_cycles", i),  32'(acc), 32'(vecs[i].cyc));
    end

    // Counter: enable, let it run, observe the wrap, then disable.
    xfer(0, 1, 32'h00, 32'h1, rd, err, acc);
    chk("cnt_en_on", 32'(count_en_v[0]), 32'h1);
    repeat (5) tick();
    xfer(0, 0, 32'h04, 32'h0, rd, err, acc);
    chk("cnt_first", rd, 32'd6);
    xfer(0, 0, 32'h04, 32'h0, rd, err, acc);
    chk("cnt_second", rd, 32'd8);
    repeat (245) tick();
    xfer(0, 0, 32'h04, 32'h0, rd, err, acc);
    chk("cnt_ff", rd, 32'h000000FF);
    xfer(0, 0, 32'h04, 32'h0, rd, err, acc);
    chk("cnt_wrap", rd, 32'h00000001);
    xfer(0, 0, 32'h00, 32'h0, rd, err, acc);
    chk("ctrl_rd_on", rd, 32'h1);
    xfer(0, 1, 32'h00, 32'h0, rd, err, acc);
    xfer(0, 0, 32'h04, 32'h0, rd, err, acc);
    chk("cnt_cleared", rd, 32'h0);
    chk("cnt_en_off", 32'(count_en_v[0]), 32'h0);

    // Stray access strobe while idle, then back-to-back write/read.
    psel_v = 3'b001; penable = 1'b1; pwrite = 1'b0; paddr = 32'h08;
    chk("stray_pready_a", 32'(pready_v[0]), 32'h0);
    tick();
    chk("stray_pready_b", 32'(pready_v[0]), 32'h0);
    psel_v = '0; penable = 1'b0;
    tick();
    xfer(0, 1, 32'h0C, 32'hA5A5F00F, rd, err, acc);
    chk("b2b_wr_err", 32'(err), 32'h0);
    xfer(0, 0, 32'h0C, 32'h0, rd, err, acc);
    chk("b2b_rd_data", rd, 32'hA5A5F00F);
    chk("b2b_rd_cycles", 32'(acc), 32'h1);

    // Reset in the middle of a waited write on the 2-wait instance.
    psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h55;
    tick();
    penable = 1'b1;
    chk("rstmid_wait1", 32'(pready_v[2]), 32'h0);
    tick();
    chk("rstmid_wait2", 32'(pready_v[2]), 32'h0);
    rst = 1'b1;
    tick();
    chk("rstmid_in_rst", 32'(pready_v[2]), 32'h0);
    rst = 1'b0;
    tick();
    chk("rstmid_after1", 32'(pready_v[2]), 32'h0);
    tick();
    chk("rstmid_after2", 32'(pready_v[2]), 32'h0);
    psel_v = '0; penable = 1'b0;
    tick();
    xfer(2, 0, 32'h0C, 32'h0, rd, err, acc);
    chk("rstmid_scratch1", rd, 32'h0);
    chk("rstmid_cycles", 32'(acc), 32'h3);

    // Abort by dropping psel during the wait states.
    psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h99;
    tick();
    penable = 1'b1;
    chk("abort_wait", 32'(pready_v[2]), 32'h0);
    psel_v = '0; penable = 1'b0;
    tick();
    chk("abort_idle", 32'(pready_v[2]), 32'h0);
    tick();
    xfer(2, 0, 32'h08, 32'h0, rd, err, acc);
    chk("abort_scratch0", rd, 32'h0);

    // Reset coinciding with a completing write must win.
    psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h77;
    tick();
    penable = 1'b1;
    tick();
    tick();
    chk("rstwin_pready", 32'(pready_v[2]), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; psel_v = '0; penable = 1'b0;
    tick();
    xfer(2, 0, 32'h0C, 32'h0, rd, err, acc);
    chk("rstwin_scratch1", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
